// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared size encodings, FSM state type and timeout default for the data-memory bus controller
package dmem_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam int DMEM_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/dmem_load_ext.sv
// rtl/dmem_load_ext.sv - combinational sign/zero extension of load data by access size
module dmem_load_ext
    import dmem_pkg::*;
#(
    parameter int BIT_WIDTH = 32
) (
    input  logic [BIT_WIDTH-1:0] raw,
    input  logic [1:0]           size,
    input  logic                 is_signed,
    output logic [BIT_WIDTH-1:0] ext
);

    // Narrow loads take the low lane; the fill bit is the lane MSB only for signed loads
    always_comb begin
        ext = raw;
        case (size)
            SZ_HALF: ext = {{(BIT_WIDTH-16){is_signed & raw[15]}}, raw[15:0]};
            SZ_BYTE: ext = {{(BIT_WIDTH-8){is_signed & raw[7]}}, raw[7:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/dmem_bus_ctrl.sv
// rtl/dmem_bus_ctrl.sv - MEM-stage data bus controller with wait timeout; optional alignment check via DMEM_ALIGN_CHECK_EN
module dmem_bus_ctrl
    import dmem_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int TIMEOUT   = DMEM_TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic                 req_signed,
    input  logic [BIT_WIDTH-1:0] req_addr,
    input  logic [BIT_WIDTH-1:0] req_wdata,
    output logic                 req_ready,
    output logic                 resp_valid,
    output logic [BIT_WIDTH-1:0] resp_rdata,
    output logic                 bus_err,
    output logic                 misalign,
    output logic [BIT_WIDTH-1:0] DAD,
    output logic                 MREQ,
    output logic                 WRITE,
    output logic [1:0]           SIZE,
    input  logic                 ACKD_n,
    inout  wire  [BIT_WIDTH-1:0] DDT
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     cnt_inc;
    logic [BIT_WIDTH-1:0] dad_q, dad_d;
    logic                 write_q, write_d;
    logic [1:0]           size_q, size_d;
    logic                 signed_q, signed_d;
    logic [BIT_WIDTH-1:0] wdata_q, wdata_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [BIT_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                 bus_err_q, bus_err_d;
    logic                 misalign_q, misalign_d;
    logic                 addr_misaligned;
    logic [BIT_WIDTH-1:0] load_data;

    // Store data is lane-formatted once at acceptance so the bus drive stays constant during BUS
    function automatic logic [BIT_WIDTH-1:0] store_image(input logic [BIT_WIDTH-1:0] d,
                                                         input logic [1:0] sz);
        case (sz)
            SZ_HALF: return {{(BIT_WIDTH-16){1'b0}}, d[15:0]};
            SZ_BYTE: return {{(BIT_WIDTH-8){1'b0}}, d[7:0]};
            default: return d;
        endcase
    endfunction

`ifdef DMEM_ALIGN_CHECK_EN
    assign addr_misaligned = ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) ||
                             ((req_size == SZ_HALF) && req_addr[0]);
`else
    assign addr_misaligned = 1'b0;
`endif

    dmem_load_ext #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_load_ext (
        .raw       (DDT),
        .size      (size_q),
        .is_signed (signed_q),
        .ext       (load_data)
    );

    assign cnt_inc = cnt_q + 1'b1;

    // Next-state and registered-output computation; pulses default low every cycle
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dad_d        = dad_q;
        write_d      = write_q;
        size_d       = size_q;
        signed_d     = signed_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        bus_err_d    = 1'b0;
        misalign_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_size == SZ_RSVD) begin
                        bus_err_d = 1'b1;
                    end else if (addr_misaligned) begin
                        misalign_d = 1'b1;
                    end else begin
                        state_d  = BUS;
                        cnt_d    = '0;
                        dad_d    = req_addr;
                        write_d  = req_write;
                        size_d   = req_size;
                        signed_d = req_signed;
                        wdata_d  = store_image(req_wdata, req_size);
                    end
                end
            end
            BUS: begin
                // Ack is checked first so it wins over a simultaneous timeout
                if (!ACKD_n) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = write_q ? '0 : load_data;
                end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    state_d   = IDLE;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            dad_q        <= '0;
            write_q      <= 1'b0;
            size_q       <= SZ_WORD;
            signed_q     <= 1'b0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            bus_err_q    <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dad_q        <= dad_d;
            write_q      <= write_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            bus_err_q    <= bus_err_d;
            misalign_q   <= misalign_d;
        end
    end

    assign MREQ       = (state_q == BUS);
    assign req_ready  = (state_q == IDLE);
    assign DAD        = dad_q;
    assign WRITE      = write_q;
    assign SIZE       = size_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign bus_err    = bus_err_q;
    assign misalign   = misalign_q;
    assign DDT        = (MREQ && write_q) ? wdata_q : {BIT_WIDTH{1'bz}};

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// tb/tb_dmem_bus_ctrl.sv - self-checking bench for dmem_bus_ctrl (honours DMEM_ALIGN_CHECK_EN)
module tb_dmem_bus_ctrl;

    localparam int          TO    = 4;
    localparam logic [31:0] PROBE = 32'h5A5A_5A5A;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, bus_err, misalign;
    logic [31:0] resp_rdata, DAD;
    logic        MREQ, WRITE, ACKD_n;
    logic [1:0]  SIZE;
    wire  [31:0] DDT;
    logic        tb_drv_en;
    logic [31:0] tb_drv_val;

    int n_checks = 0;
    int n_fail   = 0;

    assign DDT = tb_drv_en ? tb_drv_val : 32'bz;

    always #5 clk = ~clk;

    dmem_bus_ctrl #(.BIT_WIDTH(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .bus_err(bus_err), .misalign(misalign),
        .DAD(DAD), .MREQ(MREQ), .WRITE(WRITE), .SIZE(SIZE), .ACKD_n(ACKD_n), .DDT(DDT)
    );

    typedef struct {
        string       name;
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] ddt;
        int          ack_wait;
        logic [31:0] exp_rdata;
        int          exp_mreq;
        int          exp_resp;
        int          exp_err;
        int          exp_mis;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_store(input logic [31:0] d, input logic [1:0] sz);
        if (sz == 2'b01) return d % 32'h1_0000;
        if (sz == 2'b10) return d % 32'h100;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] d, input logic [1:0] sz, input logic sg);
        longint v;
        if (sz == 2'b01) begin
            v = longint'(d) % 65536;
            if (sg && v >= 32768) v = v - 65536;
        end else if (sz == 2'b10) begin
            v = longint'(d) % 256;
            if (sg && v >= 128) v = v - 256;
        end else begin
            v = longint'(d);
        end
        return v[31:0];
    endfunction

    function automatic int model_misaligned(input logic [1:0] sz, input logic [31:0] addr);
`ifdef DMEM_ALIGN_CHECK_EN
        if (sz == 2'b00 && (addr % 4) != 0) return 1;
        if (sz == 2'b01 && (addr % 2) != 0) return 1;
`endif
        return 0;
    endfunction

    task automatic run_txn(input vec_t v);
        int          mreq_cnt = 0;
        int          resp_cnt = 0;
        int          err_cnt  = 0;
        int          mis_cnt  = 0;
        logic [31:0] got_rdata = 32'h0;
        logic [31:0] exp_ddt;
        exp_ddt = model_store(v.wdata, v.sz);
        chk({v.name, ":ready_idle"}, {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_write  = v.w;
        req_size   = v.sz;
        req_signed = v.sg;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        for (int c = 0; c < TO + 4; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            ACKD_n    = 1'b1;
            if (MREQ) begin
                mreq_cnt++;
                if (v.w) begin
                    tb_drv_en = 1'b0;
                end else begin
                    tb_drv_en  = 1'b1;
                    tb_drv_val = v.ddt;
                end
                if (mreq_cnt - 1 == v.ack_wait) ACKD_n = 1'b0;
                #1;
                chk({v.name, ":dad"}, DAD, v.addr);
                chk({v.name, ":size"}, {30'b0, SIZE}, {30'b0, v.sz});
                chk({v.name, ":write"}, {31'b0, WRITE}, {31'b0, v.w});
                chk({v.name, ":ready_bus"}, {31'b0, req_ready}, 32'd0);
                if (v.w) chk({v.name, ":ddt_store"}, DDT, exp_ddt);
            end else begin
                tb_drv_en  = 1'b1;
                tb_drv_val = PROBE;
                #1;
                chk({v.name, ":ddt_hiz"}, DDT, PROBE);
            end
            if (resp_valid) begin
                resp_cnt++;
                got_rdata = resp_rdata;
            end
            if (bus_err) err_cnt++;
            if (misalign) mis_cnt++;
        end
        ACKD_n = 1'b1;
        chk({v.name, ":mreq_cycles"}, mreq_cnt, v.exp_mreq);
        chk({v.name, ":resp_pulses"}, resp_cnt, v.exp_resp);
        chk({v.name, ":err_pulses"}, err_cnt, v.exp_err);
        chk({v.name, ":mis_pulses"}, mis_cnt, v.exp_mis);
        if (v.exp_resp == 1) chk({v.name, ":rdata"}, got_rdata, v.exp_rdata);
        chk({v.name, ":ready_end"}, {31'b0, req_ready}, 32'd1);
    endtask

    function automatic vec_t model_txn(input string name, input logic w, input logic [1:0] sz,
                                       input logic sg, input logic [31:0] addr, input logic [31:0] wdata,
                                       input logic [31:0] ddt, input int ack_wait);
        vec_t v;
        v = '{name, w, sz, sg, addr, wdata, ddt, ack_wait, 32'h0, 0, 0, 0, 0};
        if (sz == 2'b11) begin
            v.exp_err = 1;
        end else if (model_misaligned(sz, addr) != 0) begin
            v.exp_mis = 1;
        end else if (ack_wait < TO) begin
            v.exp_mreq  = ack_wait + 1;
            v.exp_resp  = 1;
            v.exp_rdata = w ? 32'h0 : model_load(ddt, sz, sg);
        end else begin
            v.exp_mreq = TO;
            v.exp_err  = 1;
        end
        return v;
    endfunction

    vec_t tbl[12];

    initial begin
        int rc, ec;
        tbl[0]  = '{"ld_word",      1'b0, 2'b00, 1'b0, 32'h0800_0000, 32'h0, 32'h1234_5678, 0, 32'h1234_5678, 1, 1, 0, 0};
        tbl[1]  = '{"ld_sbyte",     1'b0, 2'b10, 1'b1, 32'h0000_0101, 32'h0, 32'h0000_0080, 1, 32'hFFFF_FF80, 2, 1, 0, 0};
        tbl[2]  = '{"ld_uhalf",     1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'h0, 32'h0000_8001, 0, 32'h0000_8001, 1, 1, 0, 0};
        tbl[3]  = '{"ld_shalf",     1'b0, 2'b01, 1'b1, 32'h0000_0204, 32'h0, 32'hABCD_8001, 2, 32'hFFFF_8001, 3, 1, 0, 0};
        tbl[4]  = '{"ld_ubyte",     1'b0, 2'b10, 1'b0, 32'h0000_0303, 32'h0, 32'h1234_56F0, 0, 32'h0000_00F0, 1, 1, 0, 0};
        tbl[5]  = '{"st_byte",      1'b1, 2'b10, 1'b0, 32'hF000_0000, 32'hAABB_CCDD, 32'h0, 2, 32'h0, 3, 1, 0, 0};
        tbl[6]  = '{"st_half",      1'b1, 2'b01, 1'b0, 32'hF000_0002, 32'hAABB_CCDD, 32'h0, 0, 32'h0, 1, 1, 0, 0};
        tbl[7]  = '{"st_word",      1'b1, 2'b00, 1'b0, 32'hF000_0004, 32'hAABB_CCDD, 32'h0, 1, 32'h0, 2, 1, 0, 0};
        tbl[8]  = '{"timeout",      1'b0, 2'b00, 1'b0, 32'h0000_1000, 32'h0, 32'h1111_1111, 99, 32'h0, TO, 0, 1, 0};
        tbl[9]  = '{"ack_at_limit", 1'b0, 2'b00, 1'b0, 32'h0000_2000, 32'h0, 32'h2222_3333, TO - 1, 32'h2222_3333, TO, 1, 0, 0};
        tbl[10] = '{"rsvd_size",    1'b0, 2'b11, 1'b0, 32'h0000_3000, 32'h0, 32'h0, 0, 32'h0, 0, 0, 1, 0};
`ifdef DMEM_ALIGN_CHECK_EN
        tbl[11] = '{"misaligned",   1'b0, 2'b00, 1'b0, 32'h0800_0002, 32'h0, 32'hCAFE_F00D, 0, 32'h0, 0, 0, 0, 1};
`else
        tbl[11] = '{"misaligned",   1'b0, 2'b00, 1'b0, 32'h0800_0002, 32'h0, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 1, 1, 0, 0};
`endif

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; ACKD_n = 1'b1; tb_drv_en = 1'b1; tb_drv_val = PROBE;
        repeat (3) @(negedge clk);
        chk("rst:mreq", {31'b0, MREQ}, 32'd0);
        chk("rst:write", {31'b0, WRITE}, 32'd0);
        chk("rst:size", {30'b0, SIZE}, 32'd0);
        chk("rst:dad", DAD, 32'h0);
        chk("rst:resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst:resp_rdata", resp_rdata, 32'h0);
        chk("rst:bus_err", {31'b0, bus_err}, 32'd0);
        chk("rst:misalign", {31'b0, misalign}, 32'd0);
        chk("rst:ready", {31'b0, req_ready}, 32'd1);
        chk("rst:ddt_hiz", DDT, PROBE);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) run_txn(tbl[i]);

        // Ack while idle must not produce a response
        rc = 0;
        ACKD_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (resp_valid) rc++;
            chk("idle_ack:mreq", {31'b0, MREQ}, 32'd0);
        end
        ACKD_n = 1'b1;
        @(negedge clk);
        if (resp_valid) rc++;
        chk("idle_ack:resp_pulses", rc, 0);

        // Reset in the second BUS cycle aborts silently
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b00; req_addr = 32'h0000_0040;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_bus:mreq1", {31'b0, MREQ}, 32'd1);
        @(negedge clk);
        chk("rst_bus:mreq2", {31'b0, MREQ}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_bus:mreq_drop", {31'b0, MREQ}, 32'd0);
        rc = 0; ec = 0;
        for (int c = 0; c < TO + 3; c++) begin
            if (resp_valid) rc++;
            if (bus_err) ec++;
            @(negedge clk);
        end
        chk("rst_bus:resp_pulses", rc, 0);
        chk("rst_bus:err_pulses", ec, 0);
        chk("rst_bus:ready", {31'b0, req_ready}, 32'd1);

        for (int i = 0; i < 40; i++) begin
            vec_t v;
            v = model_txn($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom_range(0, TO + 1));
            run_txn(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_bus_ctrl.md
DMEM_BUS_CTRL -- requirements
Module: dmem_bus_ctrl

Interface
REQ-001 Parameter BIT_WIDTH, default 32, data/address width.
REQ-002 Parameter TIMEOUT, default 255, maximum bus-wait cycles before abort.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req_valid  in  1  MEM-stage access request.
REQ-006 req_write  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  00 = word, 01 = half, 10 = byte, 11 = reserved.
REQ-008 req_signed  in  1  load sign-extend enable.
REQ-009 req_addr, req_wdata  in  BIT_WIDTH each  byte address and store data (right-justified).
REQ-010 req_ready  out  1  high only in IDLE.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 resp_rdata  out  BIT_WIDTH  extended load data, valid with resp_valid.
REQ-013 bus_err  out  1  one-cycle pulse: timeout or reserved size.
REQ-014 misalign  out  1  one-cycle pulse; tied 0 without the macro.
REQ-015 DAD  out  BIT_WIDTH; MREQ  out  1; WRITE  out  1; SIZE  out  2; ACKD_n  in  1 (active-low ack); DDT  inout  BIT_WIDTH.

Function
REQ-016 FSM states IDLE, BUS, RESP; IDLE->BUS on req_valid with legal size; BUS->RESP on ACKD_n sampled 0; RESP->IDLE unconditionally.
REQ-017 Request accepted in IDLE cycle N -> MREQ=1 with DAD/WRITE/SIZE registered from cycle N+1.
REQ-018 DAD, WRITE, SIZE, DDT drive held stable throughout BUS; MREQ=0 in IDLE and RESP.
REQ-019 DDT driven only when MREQ=1 and WRITE=1: word = wdata; half = {16'h0, wdata[15:0]}; byte = {24'h0, wdata[7:0]}; otherwise high-Z.
REQ-020 Load data captured from DDT on the edge where ACKD_n=0 -> resp_valid=1 the next cycle.
REQ-021 Extension: word raw; half -> sign/zero-extend DDT[15:0]; byte -> sign/zero-extend DDT[7:0], per req_signed.
REQ-022 Store completion also pulses resp_valid, with resp_rdata = 0.
REQ-023 Wait counter cleared on entering BUS, increments per BUS cycle; reaching TIMEOUT without ack -> IDLE, bus_err pulse, no resp_valid.
REQ-024 Ack on the same edge the counter reaches TIMEOUT: ack wins.
REQ-025 req_size=11 in IDLE: no bus cycle, bus_err pulse next cycle, stay IDLE.
REQ-026 ACKD_n=0 while in IDLE or RESP ignored; req_valid outside IDLE ignored (req_ready=0).

Reset
REQ-027 rst=1 at an edge -> IDLE, MREQ=0, WRITE=0, SIZE=00, DAD=0, DDT high-Z, resp_valid=0, resp_rdata=0, bus_err=0, misalign=0, counter=0.
REQ-028 rst mid-BUS aborts the access: MREQ drops next cycle, no resp_valid or bus_err.

Configuration
REQ-029 DMEM_ALIGN_CHECK_EN defined: word with addr[1:0]!=0 or half with addr[0]!=0 -> no bus cycle, misalign pulse next cycle, stay IDLE.
REQ-030 DMEM_ALIGN_CHECK_EN undefined: address passed unchanged, misalign constant 0.

Structure
REQ-031 Shared package dmem_pkg holds size encodings (SZ_WORD, SZ_HALF, SZ_BYTE), FSM state type, TIMEOUT default.
REQ-032 Load extension in sub-module dmem_load_ext (combinational); FSM, counter, tristate in dmem_bus_ctrl.

Verification
REQ-033 Load word 0x0800_0000, ack after 1 cycle, DDT=0x1234_5678 -> resp_rdata=0x1234_5678, MREQ high exactly 1 cycle.
REQ-034 Signed byte load, DDT=0x0000_0080 -> 0xFFFF_FF80; unsigned half, DDT=0x0000_8001 -> 0x0000_8001.
REQ-035 Byte store wdata=0xAABB_CCDD to 0xF000_0000 -> DDT=0x0000_00DD, SIZE=10, WRITE=1 until ack; then DDT high-Z.
REQ-036 No ack, TIMEOUT=4 -> MREQ high 4 cycles, then bus_err pulse, req_ready=1.
REQ-037 rst asserted in 2nd BUS cycle -> MREQ=0 next cycle, no resp_valid; misaligned word 0x0800_0002 with macro -> misalign pulse, MREQ stays 0.
